// File: rtl/alu_ram_sequencer_pkg.sv
// Shared definitions for the ALU/RAM command sequencer: default widths,
// opcode encodings and the sequencer FSM state type.
package alu_ram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 8;

    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b0110;
    localparam logic [3:0] OP_DIV  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NAND = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_XNOR = 4'b1101;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        EXEC,
        WB,
        ERR
    } state_t;

endpackage

// File: rtl/alu_ram_sequencer_if.sv
// Command, RAM and ALU signal bundle of the sequencer. The slave modport is
// the sequencer's view; master is the surrounding system (command source,
// RAM and ALU).
interface alu_ram_sequencer_if #(
    parameter int DATA_W = alu_ram_pkg::DEF_DATA_W,
    parameter int ADDR_W = alu_ram_pkg::DEF_ADDR_W
) ();

    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_y;

    logic              done;
    logic              err;
    logic              zf;
    logic              busy;
    logic [15:0]       op_cnt;

    modport slave (
        input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, ram_rdata, alu_y,
        output cmd_ready, ram_addr, ram_we, ram_wdata, alu_a, alu_b, alu_op,
        output done, err, zf, busy, op_cnt
    );

    modport master (
        output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, ram_rdata, alu_y,
        input  cmd_ready, ram_addr, ram_we, ram_wdata, alu_a, alu_b, alu_op,
        input  done, err, zf, busy, op_cnt
    );

endinterface

// File: rtl/alu_ram_sequencer_alu_op_decode.sv
// Combinational opcode classifier: flags opcodes the ALU implements and
// singles out division, which needs a divide-by-zero guard.
module alu_op_decode
    import alu_ram_pkg::*;
(
    input  logic [3:0] i_op,
    output logic       o_valid,
    output logic       o_is_div
);

    // Valid opcodes form the contiguous range ADD..XNOR.
    assign o_valid  = (i_op >= OP_ADD) && (i_op <= OP_XNOR);
    assign o_is_div = (i_op == OP_DIV);

endmodule

// File: rtl/alu_ram_sequencer.sv
// Sequencer that reads two operands from an external synchronous RAM, runs
// them through an external combinational ALU and writes the result back.
module alu_ram_sequencer
    import alu_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_ram_sequencer_if.slave   bus
);

    state_t            r_state;
    logic [3:0]        r_op;
    logic              r_is_div;
    logic [ADDR_W-1:0] r_src_b;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_result;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_we;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [3:0]        r_alu_op;
    logic              r_done;
    logic              r_err;
    logic              r_zf;
    logic [15:0]       r_op_cnt;

    logic              w_op_valid;
    logic              w_op_is_div;

    alu_op_decode u_decode (
        .i_op     (bus.cmd_op),
        .o_valid  (w_op_valid),
        .o_is_div (w_op_is_div)
    );

    assign bus.cmd_ready = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.ram_addr  = r_ram_addr;
    assign bus.ram_we    = r_ram_we;
    assign bus.ram_wdata = r_result;
    assign bus.alu_a     = r_alu_a;
    assign bus.alu_b     = r_alu_b;
    assign bus.alu_op    = r_alu_op;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.zf        = r_zf;
    assign bus.op_cnt    = r_op_cnt;

    // Outputs are registered one edge ahead so each takes its value for the whole state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_op       <= '0;
            r_is_div   <= 1'b0;
            r_src_b    <= '0;
            r_dst      <= '0;
            r_opa      <= '0;
            r_result   <= '0;
            r_ram_addr <= '0;
            r_ram_we   <= 1'b0;
            r_alu_a    <= '0;
            r_alu_b    <= '0;
            r_alu_op   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_zf       <= 1'b0;
            r_op_cnt   <= '0;
        end else begin
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ram_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        r_op     <= bus.cmd_op;
                        r_is_div <= w_op_is_div;
                        r_src_b  <= bus.cmd_src_b;
                        r_dst    <= bus.cmd_dst;
                        if (w_op_valid) begin
                            r_ram_addr <= bus.cmd_src_a;
                            r_state    <= RD_A;
                        end else begin
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_op_cnt <= r_op_cnt + 16'd1;
                            r_state  <= ERR;
                        end
                    end
                end
                RD_A: begin
                    r_ram_addr <= r_src_b;
                    r_state    <= RD_B;
                end
                RD_B: begin
                    r_opa      <= bus.ram_rdata;
                    r_ram_addr <= '0;
                    r_state    <= CAP_B;
                end
                CAP_B: begin
                    r_alu_a  <= r_opa;
                    r_alu_b  <= bus.ram_rdata;
                    r_alu_op <= r_op;
                    r_state  <= EXEC;
                end
                EXEC: begin
                    // A zero divisor aborts without touching the result, the flag or the RAM.
                    if (r_is_div && (r_alu_b == '0)) begin
                        r_done   <= 1'b1;
                        r_err    <= 1'b1;
                        r_op_cnt <= r_op_cnt + 16'd1;
                        r_state  <= ERR;
                    end else begin
                        r_result   <= bus.alu_y;
                        r_zf       <= (bus.alu_y == '0);
                        r_ram_addr <= r_dst;
                        r_ram_we   <= 1'b1;
                        r_done     <= 1'b1;
                        r_op_cnt   <= r_op_cnt + 16'd1;
                        r_state    <= WB;
                    end
                end
                WB: begin
                    r_ram_addr <= '0;
                    r_state    <= IDLE;
                end
                ERR: begin
                    r_ram_addr <= '0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_ram_addr <= '0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_ram_sequencer.md
ALU_RAM_SEQUENCER -- requirements
Module: alu_ram_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: datapath width.
REQ-002 The block SHALL have parameter ADDR_W, default 8: RAM address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1: rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 The block SHALL have port cmd_valid, input, 1: command present.
REQ-007 The block SHALL have port cmd_ready, output, 1: block is idle and accepts a command.
REQ-008 The block SHALL have port cmd_op, input, 4: ALU opcode.
REQ-009 The block SHALL have ports cmd_src_a, cmd_src_b and cmd_dst, input, ADDR_W each: operand A, operand B and destination RAM addresses.
REQ-010 The block SHALL have ports ram_addr (output, ADDR_W), ram_we (output, 1), ram_wdata (output, DATA_W) and ram_rdata (input, DATA_W): single-port synchronous RAM with 1-cycle read latency.
REQ-011 The block SHALL have ports alu_a and alu_b (output, DATA_W), alu_op (output, 4) and alu_y (input, DATA_W): external combinational ALU.
REQ-012 The block SHALL have ports done (output, 1: completion pulse), err (output, 1: error pulse, coincident with done), zf (output, 1: registered zero flag of last result), busy (output, 1: not idle) and op_cnt (output, 16: count of completed commands).

Function
REQ-013 The FSM SHALL have states IDLE, RD_A, RD_B, CAP_B, EXEC, WB and ERR.
REQ-014 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a clock edge where cmd_valid and cmd_ready are both 1, with all cmd_* fields latched at that edge.
REQ-015 Valid opcodes SHALL be 0100 add, 0101 sub, 0110 mul, 0111 div, 1000 and, 1001 or, 1010 nand, 1011 nor, 1100 xor and 1101 xnor; any other opcode SHALL go IDLE->ERR.
REQ-016 For a valid opcode the sequence SHALL be IDLE->RD_A (ram_addr=src_a)->RD_B (ram_addr=src_b; capture ram_rdata as A)->CAP_B (capture ram_rdata as B)->EXEC->WB->IDLE.
REQ-017 In EXEC, alu_a, alu_b and alu_op SHALL carry the latched operands and opcode, and alu_y SHALL be registered into the result register.
REQ-018 In EXEC, zf SHALL update to (alu_y==0); zf SHALL hold its value at all other times, including error commands.
REQ-019 In WB, the outputs SHALL be ram_addr=dst, ram_we=1 and ram_wdata=result, with done=1 in the same cycle; the block SHALL return to IDLE on the next edge.
REQ-020 For div (0111) with B==0, detected in EXEC, the FSM SHALL go EXEC->ERR, and no RAM write SHALL occur.
REQ-021 ERR SHALL last one cycle with done=1, err=1 and ram_we=0, then return to IDLE.
REQ-022 ram_we SHALL be 1 only in WB.
REQ-023 ram_addr SHALL be 0 in IDLE and ERR.
REQ-024 alu_a, alu_b and alu_op SHALL hold their last values outside EXEC.
REQ-025 Arithmetic results SHALL be truncated to DATA_W bits (mul low half, sub modulo 2^DATA_W, div unsigned quotient).
REQ-026 Latency for a valid command SHALL be accept at edge 0, with done high in cycle 5 (WB); the next command SHALL be acceptable at edge 6; sustained throughput SHALL be 1 command per 6 cycles.
REQ-027 op_cnt SHALL increment by 1 in every cycle with done=1, including errors, and SHALL wrap 0xFFFF->0x0000.
REQ-028 cmd_valid while busy SHALL be ignored and SHALL NOT be latched.
REQ-029 Any of cmd_src_a, cmd_src_b and cmd_dst MAY alias: operands are read before the write, so RAM[dst] SHALL reflect the result computed from the pre-write values.

Reset
REQ-030 On rst_n=0 the block SHALL enter IDLE asynchronously with state=IDLE, ram_we=0, ram_addr=0, ram_wdata=0, alu_a=0, alu_b=0, alu_op=0, done=0, err=0, zf=0, busy=0, op_cnt=0 and operand/result registers cleared.
REQ-031 Reset asserted mid-command SHALL abort the command with no RAM write, and no done pulse SHALL follow reset release.
REQ-032 cmd_ready SHALL be 1 in the first cycle after rst_n deasserts.

Structure
REQ-033 A shared package alu_ram_pkg SHALL hold the opcode constants (OP_ADD..OP_XNOR), the FSM state enum and the default widths.
REQ-034 One sub-module, alu_op_decode (combinational: opcode -> valid, is_div), SHALL be used by this block and be reusable elsewhere.
REQ-035 The ALU and RAM SHALL remain external.

Verification
REQ-036 RAM[0x10]=7, RAM[0x11]=5, op=0100, dst=0x12 -> ram_we in cycle 5 with ram_wdata=12, RAM[0x12]=12, zf=0, op_cnt=1.
REQ-037 RAM[0x20]=5, RAM[0x21]=5, op=0101, dst=0x20 (aliased) -> RAM[0x20]=0, zf=1.
REQ-038 RAM[0x30]=9, RAM[0x31]=0, op=0111 -> done=err=1 in cycle 5, no write, zf unchanged, op_cnt increments.
REQ-039 op=0000 -> done=err=1 in cycle 1, cmd_ready=1 in cycle 2, no RAM reads or writes beyond address 0.
REQ-040 Two commands with cmd_valid held continuously -> accepts at edges 0 and 6; RAM[0x40]=0x10000 squared via op=0110 -> result 0 and zf=1.
REQ-041 rst_n pulsed low during EXEC -> no ram_we, all outputs at reset values, and a fresh command completes normally afterward.
